// File: rtl/cpu_board_pkg.sv
// Shared encodings for the board-level CPU run controller: FSM states,
// LED display selects and the default halt opcode.
package cpu_board_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } run_state_e;

  localparam logic [1:0] DISP_REGS   = 2'd0;
  localparam logic [1:0] DISP_PC     = 2'd1;
  localparam logic [1:0] DISP_COUNT  = 2'd2;
  localparam logic [1:0] DISP_STATUS = 2'd3;

  localparam logic [31:0] HALT_INST_DEFAULT = 32'h0000_000C;

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button conditioner: 2-flop synchroniser, stable-level counter,
// and a single-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back to the old level restarts it.
  assign w_accept = (r_sync[1] != r_level) && (r_cnt == CW'(DB_CYCLES - 1));
  assign o_press  = w_accept & r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle CPU: produces the one-clock
// commit enable, counts retired instructions and drives the 8 front-panel LEDs.
module cpu_run_ctrl
  import cpu_board_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_btn,
  input  logic                 step_btn,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          pc,
  input  logic [31:0]          inst,
  input  logic [1:0]           disp_sel,
  input  logic [7:0]           reg_view,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] inst_count,
  output logic [7:0]           led
);

  run_state_e           r_state, w_state_nxt;
  logic                 r_cpu_en, w_en_nxt;
  logic                 r_skip_bp, w_skip_nxt;
  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic [CNT_WIDTH-1:0] r_inst_count;
  logic [7:0]           r_led;
  logic [7:0]           w_cnt_led;
  logic                 w_run_press, w_step_press, w_tick, w_bp_hit, w_halt_inst;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .i_clk(clk), .i_rst_n(reset), .i_btn(run_btn), .o_press(w_run_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .i_clk(clk), .i_rst_n(reset), .i_btn(step_btn), .o_press(w_step_press)
  );

  assign w_tick      = &r_tick_cnt;
  assign w_halt_inst = (inst == HALT_INST);
  assign w_bp_hit    = bp_en && (pc == bp_addr) && !r_skip_bp;

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_skip_nxt  = r_skip_bp;
    case (r_state)
      ST_PAUSE: begin
        if (w_run_press) begin
          w_state_nxt = ST_RUN;
          w_skip_nxt  = 1'b1;
        end else if (w_step_press && !w_halt_inst) begin
          w_en_nxt   = 1'b1;
          w_skip_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_run_press) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick) begin
          if (w_halt_inst) begin
            w_state_nxt = ST_HALTED;
          end else if (w_bp_hit) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            w_en_nxt   = 1'b1;
            w_skip_nxt = 1'b0;
          end
        end
      end
      ST_HALTED: ;
      default: w_state_nxt = ST_PAUSE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_PAUSE;
      r_cpu_en     <= 1'b0;
      r_skip_bp    <= 1'b1;
      r_tick_cnt   <= '0;
      r_inst_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_en   <= w_en_nxt;
      r_skip_bp  <= w_skip_nxt;
      r_tick_cnt <= r_tick_cnt + DIV_WIDTH'(1);
      // Count moves with the enable so both are visible in the same cycle.
      if (w_en_nxt) r_inst_count <= r_inst_count + CNT_WIDTH'(1);
    end
  end

  generate
    if (CNT_WIDTH >= 8) begin : g_cnt_wide
      assign w_cnt_led = r_inst_count[7:0];
    end else begin : g_cnt_narrow
      assign w_cnt_led = {{(8 - CNT_WIDTH){1'b0}}, r_inst_count};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
    end else begin
      case (disp_sel)
        DISP_REGS:  r_led <= reg_view;
        DISP_PC:    r_led <= pc[7:0];
        DISP_COUNT: r_led <= w_cnt_led;
        default:    r_led <= {r_state, bp_en, r_skip_bp, 4'b0000};
      endcase
    end
  end

  assign cpu_en     = r_cpu_en;
  assign state      = r_state;
  assign inst_count = r_inst_count;
  assign led        = r_led;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus pushes the expected cycle and count
// of every enable pulse; a negedge monitor pops and checks each pulse it sees.
module tb_cpu_run_ctrl;

  localparam int TICK = 16;
  localparam logic [31:0] HALT = 32'h0000_000C;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, run_btn, step_btn, bp_en;
  logic [31:0] bp_addr, pc, inst;
  logic [1:0]  disp_sel;
  logic [7:0]  reg_view;
  logic        cpu_en, cpu_en_w;
  logic [1:0]  state, state_w;
  logic [15:0] inst_count;
  logic [3:0]  inst_count_w;
  logic [7:0]  led, led_w;

  int   cyc = 0;
  int   rel = 0;
  int   total = 0;
  int   bad = 0;
  int   T, T2, T3;
  exp_t exp_q[$];

  cpu_run_ctrl #(.DIV_WIDTH(4), .DB_CYCLES(3), .CNT_WIDTH(16), .HALT_INST(HALT)) u_dut (
    .clk(clk), .reset(reset), .run_btn(run_btn), .step_btn(step_btn), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .inst(inst), .disp_sel(disp_sel), .reg_view(reg_view),
    .cpu_en(cpu_en), .state(state), .inst_count(inst_count), .led(led)
  );

  // Narrow-counter twin: identical inputs, used to exercise counter wrap quickly.
  cpu_run_ctrl #(.DIV_WIDTH(4), .DB_CYCLES(3), .CNT_WIDTH(4), .HALT_INST(HALT)) u_dut_w (
    .clk(clk), .reset(reset), .run_btn(run_btn), .step_btn(step_btn), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .inst(inst), .disp_sel(disp_sel), .reg_view(reg_view),
    .cpu_en(cpu_en_w), .state(state_w), .inst_count(inst_count_w), .led(led_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Ticks occur on edges that are a multiple of TICK after reset release.
  function automatic int next_tick(input int c);
    return rel + ((c - rel) / TICK + 1) * TICK;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press_run_at(input int p);
    wait_until(p);
    run_btn = 1'b1;
    repeat (6) @(negedge clk);
    run_btn = 1'b0;
  endtask

  logic prev_en = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (cpu_en === 1'b1 || cpu_en_w === 1'b1) begin
      check("twin_en", cpu_en_w, cpu_en);
      if (cpu_en === 1'b1) begin
        check("en_not_back_to_back", prev_en, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got cpu_en=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_count", inst_count, e.cnt & 32'hFFFF);
          check("pulse_count_w", inst_count_w, e.cnt & 32'hF);
        end
      end
    end
    prev_en = (cpu_en === 1'b1);
  end

  initial begin
    reset = 1'b0; run_btn = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = '0; pc = '0; inst = '0; disp_sel = 2'd0; reg_view = 8'h00;

    // 1: reset and idle
    repeat (5) @(negedge clk);
    check("rst_state", state, 2'b00);
    check("rst_en", cpu_en, 1'b0);
    check("rst_count", inst_count, 0);
    check("rst_led", led, 8'h00);
    reset = 1'b1;
    rel = cyc;
    repeat (4) begin
      repeat (10) @(negedge clk);
      check("idle_state", state, 2'b00);
      check("idle_count", inst_count, 0);
      check("idle_led", led, 8'h00);
    end

    // 2: clean step press, then bounced step press
    exp_q.push_back('{cyc + 5, 1});
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("step_count", inst_count, 1);
    check("step_state", state, 2'b00);
    exp_q.push_back('{cyc + 7, 2});
    step_btn = 1'b1; @(negedge clk);
    step_btn = 1'b0; @(negedge clk);
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_count", inst_count, 2);
    check_drained("step_drained");

    // LED source selection
    reg_view = 8'hA5; disp_sel = 2'd0; repeat (2) @(negedge clk);
    check("led_regs", led, 8'hA5);
    pc = 32'h123; disp_sel = 2'd1; repeat (2) @(negedge clk);
    check("led_pc", led, 8'h23);
    disp_sel = 2'd2; repeat (2) @(negedge clk);
    check("led_count", led, 8'h02);
    disp_sel = 2'd3; repeat (2) @(negedge clk);
    check("led_status_pause", led, 8'h10);

    // 3: free run, five ticks, then pause
    pc = 32'h100;
    T = next_tick(cyc + 21);
    for (int i = 0; i < 5; i++) exp_q.push_back('{T + i * TICK, 3 + i});
    press_run_at(T - 13);
    wait_until(T + 2);
    check("run_state", state, 2'b01);
    check("led_status_run", led, 8'h40);
    press_run_at(T + 4 * TICK + 3);
    wait_until(T + 4 * TICK + 10);
    check("pause_state", state, 2'b00);
    check("run_count", inst_count, 7);
    check_drained("run_drained");

    // 4: breakpoint stop, then resume executes the breakpoint instruction once
    bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h0C;
    T = next_tick(cyc + 21);
    exp_q.push_back('{T, 8});
    press_run_at(T - 13);
    wait_until(T);
    pc = 32'h10;
    T2 = T + TICK;
    wait_until(T2 + 2);
    check("bp_state", state, 2'b00);
    check("bp_led", led, 8'h20);
    check("bp_count", inst_count, 8);
    T3 = next_tick(cyc + 21);
    exp_q.push_back('{T3, 9});
    exp_q.push_back('{T3 + TICK, 10});
    press_run_at(T3 - 13);
    wait_until(T3 - 6);
    check("resume_led", led, 8'h70);
    wait_until(T3);
    pc = 32'h14;
    press_run_at(T3 + TICK + 3);
    wait_until(T3 + TICK + 10);
    check("resume_state", state, 2'b00);
    check("resume_count", inst_count, 10);
    check_drained("bp_drained");

    // step on halt opcode while paused does nothing
    inst = HALT;
    step_btn = 1'b1;
    repeat (8) @(negedge clk);
    step_btn = 1'b0;
    repeat (16) @(negedge clk);
    check("halt_step_state", state, 2'b00);
    check("halt_step_count", inst_count, 10);

    // 5: halt on tick in RUN; buttons ignored while halted
    bp_en = 1'b0;
    T = next_tick(cyc + 21);
    press_run_at(T - 13);
    wait_until(T + 2);
    check("halted_state", state, 2'b10);
    check("halted_led", led, 8'h90);
    run_btn = 1'b1; step_btn = 1'b1;
    repeat (8) @(negedge clk);
    run_btn = 1'b0; step_btn = 1'b0;
    repeat (40) @(negedge clk);
    check("halted_hold_state", state, 2'b10);
    check("halted_hold_count", inst_count, 10);
    check_drained("halt_drained");
    reset = 1'b0;
    #1;
    check("halt_rst_state", state, 2'b00);
    check("halt_rst_count", inst_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rel = cyc;
    inst = 32'h0;
    repeat (2) @(negedge clk);

    // reset asserted while the enable pulse is high
    exp_q.push_back('{cyc + 5, 1});
    T = cyc;
    step_btn = 1'b1;
    wait_until(T + 5);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_pulse_en", cpu_en, 1'b0);
    check("rst_mid_pulse_count", inst_count, 0);
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rel = cyc;
    repeat (2) @(negedge clk);
    check_drained("mid_pulse_drained");

    // 6: run+step together (run wins), 17 ticks wrapping the narrow counter,
    //    then a run press landing exactly on a tick edge
    T = next_tick(cyc + 21);
    for (int i = 0; i < 17; i++) exp_q.push_back('{T + i * TICK, i + 1});
    wait_until(T - 13);
    run_btn = 1'b1; step_btn = 1'b1;
    repeat (6) @(negedge clk);
    run_btn = 1'b0; step_btn = 1'b0;
    press_run_at(T + 17 * TICK - 5);
    wait_until(T + 17 * TICK + 3);
    check("tick_press_state", state, 2'b00);
    check("tick_press_count", inst_count, 17);
    check("wrap_count_w", inst_count_w, 4'd1);
    repeat (20) @(negedge clk);
    check_drained("final_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
